// File: rtl/rom_port_pkg.sv
// rom_port_pkg: shared state type, width defaults and
// word-to-halfword address mapping for the ROM responder.
package rom_port_pkg;

    localparam int ADDR_W_DEF = 20;
    localparam int SDR_AW_DEF = 24;

    typedef enum logic [1:0] {
        IDLE,
        RD_HI,
        RD_LO
    } rom_state_t;

    // High-half SDRAM address of a 32-bit word index.
    function automatic logic [31:0] word_to_half(
        input logic [31:0] base,
        input logic [31:0] widx
    );
        return base + (widx << 1);
    endfunction

endpackage

// File: rtl/tile_rom_responder.sv
// tile_rom_responder: serves 32-bit ROM words to the cache
// by issuing two 16-bit SDRAM reads, big-endian assembled.
module tile_rom_responder
    import rom_port_pkg::*;
#(
    parameter int                ADDR_W = ADDR_W_DEF,
    parameter int                SDR_AW = SDR_AW_DEF,
    parameter logic [SDR_AW-1:0] BASE   = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              rom_req,
    input  logic [ADDR_W-1:0] rom_addr,
    output logic [31:0]       rom_data,
    output logic              rom_valid,
    output logic              sdr_req,
    output logic [SDR_AW-1:0] sdr_addr,
    input  logic              sdr_ack,
    input  logic [15:0]       sdr_data
);

    rom_state_t        r_state;
    logic [ADDR_W-1:0] r_cur_addr;
    logic [15:0]       r_hi;
    logic              r_have;
    logic [31:0]       r_rom_data;
    logic              r_rom_valid;
    logic              r_sdr_req;
    logic [SDR_AW-1:0] r_sdr_addr;

    rom_state_t        w_state_nx;
    logic [ADDR_W-1:0] w_cur_nx;
    logic [15:0]       w_hi_nx;
    logic              w_have_nx;
    logic [31:0]       w_data_nx;
    logic              w_valid_nx;
    logic              w_req_nx;
    logic [SDR_AW-1:0] w_saddr_nx;
    logic              w_match;
    logic              w_new_req;
    logic [SDR_AW-1:0] w_hi_addr;

    assign w_match   = rom_req && (rom_addr == r_cur_addr);
    assign w_new_req = rom_req && (!r_have || (rom_addr != r_cur_addr));
    assign w_hi_addr = SDR_AW'(word_to_half(32'(BASE), 32'(rom_addr)));

    // Next-state and next-register values; fetches are never
    // aborted, so a dropped or changed request only blocks valid.
    always_comb begin
        w_state_nx = r_state;
        w_cur_nx   = r_cur_addr;
        w_hi_nx    = r_hi;
        w_have_nx  = r_have;
        w_data_nx  = r_rom_data;
        w_req_nx   = r_sdr_req;
        w_saddr_nx = r_sdr_addr;
        w_valid_nx = (r_state == IDLE) && r_have && w_match;
        unique case (r_state)
            IDLE: begin
                if (w_new_req) begin
                    w_cur_nx   = rom_addr;
                    w_have_nx  = 1'b0;
                    w_valid_nx = 1'b0;
                    w_req_nx   = 1'b1;
                    w_saddr_nx = w_hi_addr;
                    w_state_nx = RD_HI;
                end
            end
            RD_HI: begin
                if (sdr_ack) begin
                    w_hi_nx    = sdr_data;
                    w_saddr_nx = r_sdr_addr + SDR_AW'(1);
                    w_state_nx = RD_LO;
                end
            end
            RD_LO: begin
                if (sdr_ack) begin
                    w_data_nx  = {r_hi, sdr_data};
                    w_req_nx   = 1'b0;
                    w_have_nx  = 1'b1;
                    w_valid_nx = w_match;
                    w_state_nx = IDLE;
                end
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_cur_addr  <= '0;
            r_hi        <= '0;
            r_have      <= 1'b0;
            r_rom_data  <= '0;
            r_rom_valid <= 1'b0;
            r_sdr_req   <= 1'b0;
            r_sdr_addr  <= '0;
        end else begin
            r_state     <= w_state_nx;
            r_cur_addr  <= w_cur_nx;
            r_hi        <= w_hi_nx;
            r_have      <= w_have_nx;
            r_rom_data  <= w_data_nx;
            r_rom_valid <= w_valid_nx;
            r_sdr_req   <= w_req_nx;
            r_sdr_addr  <= w_saddr_nx;
        end
    end

    assign rom_data  = r_rom_data;
    assign rom_valid = r_rom_valid;
    assign sdr_req   = r_sdr_req;
    assign sdr_addr  = r_sdr_addr;

endmodule

// File: tb/tb_tile_rom_responder.sv
// tb_tile_rom_responder: scoreboard bench with an SDRAM
// responder model and a word-level reference of ROM contents.
module tb_tile_rom_responder;

    localparam logic [23:0] BASE = 24'h100000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        rom_req = 1'b0;
    logic [19:0] rom_addr = '0;
    logic [31:0] rom_data;
    logic        rom_valid;
    logic        sdr_req;
    logic [23:0] sdr_addr;
    logic        sdr_ack = 1'b0;
    logic [15:0] sdr_data = '0;

    int total = 0;
    int bad = 0;

    typedef struct packed {
        logic [19:0] a;
        logic [31:0] d;
    } exp_t;
    exp_t sbq[$];

    always #5 clk = ~clk;

    tile_rom_responder #(
        .ADDR_W(20),
        .SDR_AW(24),
        .BASE  (BASE)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .rom_req  (rom_req),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .rom_valid(rom_valid),
        .sdr_req  (sdr_req),
        .sdr_addr (sdr_addr),
        .sdr_ack  (sdr_ack),
        .sdr_data (sdr_data)
    );

    // SDRAM contents as a function of 16-bit word address
    function automatic logic [15:0] mem(input logic [23:0] a);
        logic [15:0] m;
        if (a == 24'h100024) return 16'hDEAD;
        if (a == 24'h100025) return 16'hBEEF;
        m = a[15:0] * 16'h9E37;
        return m ^ a[23:8] ^ 16'h5A5A;
    endfunction

    // ROM word w = high half at BASE+2w, low half at BASE+2w+1
    function automatic logic [31:0] ref_word(input logic [19:0] w);
        logic [23:0] h;
        h = BASE + 24'(w) * 24'd2;
        return {mem(h), mem(h + 24'd1)};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    // SDRAM responder model
    int          lat_fix = 0;
    int          spur_cnt = 0;
    int          spur_seen = 0;
    int          cnt = -1;
    logic [23:0] cap = '0;
    logic [23:0] off;
    logic [23:0] served[$];
    bit          held_ok = 0;
    logic [19:0] held_w = '0;

    always @(posedge clk) begin
        #1;
        sdr_ack = 1'b0;
        if (!reset_n) held_ok = 0;
        if (spur_cnt != spur_seen) begin
            spur_seen = spur_cnt;
            sdr_ack = 1'b1;
            sdr_data = 16'h1234;
        end else if (cnt == 0) begin
            sdr_ack = 1'b1;
            sdr_data = mem(cap);
            served.push_back(cap);
            cnt = -1;
            off = cap - BASE;
            if (off[0] && reset_n) begin
                held_w = off[20:1];
                held_ok = 1;
            end
        end else if (cnt > 0) begin
            cnt--;
        end else if (sdr_req) begin
            cap = sdr_addr;
            cnt = (lat_fix > 0) ? lat_fix - 1 : int'($urandom_range(0, 3));
        end
    end

    // Monitor: valid data must match the address presented the
    // cycle before; each rise of rom_valid consumes one entry.
    logic        p_req = 1'b0;
    logic [19:0] p_addr = '0;
    logic        p_valid = 1'b0;
    exp_t        e;

    always @(negedge clk) begin
        if (!reset_n) begin
            p_req = 1'b0;
            p_valid = 1'b0;
        end else begin
            if (rom_valid) begin
                total++;
                if (!p_req || rom_data !== ref_word(p_addr)) begin
                    bad++;
                    $display("FAIL valid_data addr=%h req=%b act=%h exp=%h",
                             p_addr, p_req, rom_data, ref_word(p_addr));
                end
                if (!p_valid) begin
                    total++;
                    if (sbq.size() == 0) begin
                        bad++;
                        $display("FAIL sb_unexpected act=%h exp=none",
                                 rom_data);
                    end else begin
                        e = sbq.pop_front();
                        if (e.a !== p_addr || e.d !== rom_data) begin
                            bad++;
                            $display("FAIL sb_match act=%h/%h exp=%h/%h",
                                     p_addr, rom_data, e.a, e.d);
                        end
                    end
                end
            end
            p_req = rom_req;
            p_addr = rom_addr;
            p_valid = rom_valid;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [19:0] x);
        exp_t n;
        n.a = x;
        n.d = ref_word(x);
        sbq.push_back(n);
    endtask

    task automatic wait_valid(input string nm, input int bound);
        bit got;
        got = 0;
        for (int i = 0; i < bound && !got; i++) begin
            tick();
            if (rom_valid) got = 1;
        end
        chk(nm, 32'(got), 32'd1);
    endtask

    task automatic wait_ack(input string nm, input int bound);
        bit got;
        got = 0;
        for (int i = 0; i < bound && !got; i++) begin
            tick();
            if (sdr_ack) got = 1;
        end
        chk(nm, 32'(got), 32'd1);
    endtask

    int          n0;
    int          acks;
    bit          done;
    int          mode;
    logic [19:0] a;
    logic [19:0] b;

    initial begin
        tick();
        tick();
        chk("rst_valid", 32'(rom_valid), 32'd0);
        chk("rst_sdr_req", 32'(sdr_req), 32'd0);
        chk("rst_sdr_addr", 32'(sdr_addr), 32'd0);
        chk("rst_data", rom_data, 32'd0);
        reset_n = 1'b1;
        tick();

        // fetch with ack latency 3
        lat_fix = 3;
        n0 = served.size();
        rom_addr = 20'h00012;
        rom_req = 1'b1;
        push(20'h00012);
        acks = 0;
        done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            tick();
            if (acks == 2) begin
                chk("t2_valid_after_ack2", 32'(rom_valid), 32'd1);
                done = 1;
            end else if (sdr_ack) begin
                acks++;
                chk("t2_req_held", 32'(sdr_req), 32'd1);
                chk("t2_no_early_valid", 32'(rom_valid), 32'd0);
                if (acks == 1)
                    chk("t2_addr_hi", 32'(sdr_addr), 32'h100024);
                else
                    chk("t2_addr_lo", 32'(sdr_addr), 32'h100025);
            end
        end
        chk("t2_done", 32'(done), 32'd1);
        chk("t2_data", rom_data, 32'hDEADBEEF);
        chk("t2_traffic", 32'(served.size() - n0), 32'd2);

        // re-request of the held word
        rom_req = 1'b0;
        tick();
        chk("t3_drop", 32'(rom_valid), 32'd0);
        tick();
        n0 = served.size();
        rom_req = 1'b1;
        push(20'h00012);
        tick();
        chk("t3_hit", 32'(rom_valid), 32'd1);
        chk("t3_no_sdr", 32'(sdr_req), 32'd0);
        tick();
        tick();
        chk("t3_traffic", 32'(served.size() - n0), 32'd0);
        rom_req = 1'b0;
        tick();
        tick();

        // request dropped between the two acks
        lat_fix = 2;
        n0 = served.size();
        rom_addr = 20'h00040;
        rom_req = 1'b1;
        wait_ack("t4_ack1", 20);
        rom_req = 1'b0;
        repeat (10) tick();
        chk("t4_no_valid", 32'(rom_valid), 32'd0);
        chk("t4_traffic", 32'(served.size() - n0), 32'd2);
        n0 = served.size();
        rom_req = 1'b1;
        push(20'h00040);
        tick();
        chk("t4_hit", 32'(rom_valid), 32'd1);
        chk("t4_no_sdr", 32'(sdr_req), 32'd0);
        rom_req = 1'b0;
        tick();
        tick();

        // address change while the low half is outstanding
        n0 = served.size();
        rom_addr = 20'h00012;
        rom_req = 1'b1;
        wait_ack("t5_ack1", 20);
        rom_addr = 20'h00013;
        push(20'h00013);
        wait_valid("t5_valid", 40);
        chk("t5_data", rom_data, ref_word(20'h00013));
        chk("t5_traffic", 32'(served.size() - n0), 32'd4);
        if (served.size() - n0 == 4) begin
            chk("t5_addr0", 32'(served[n0]), 32'h100024);
            chk("t5_addr2", 32'(served[n0 + 2]), 32'h100026);
            chk("t5_addr3", 32'(served[n0 + 3]), 32'h100027);
        end
        rom_req = 1'b0;
        tick();
        tick();

        // spurious ack while idle
        spur_cnt++;
        repeat (3) tick();
        chk("t6_data_kept", rom_data, ref_word(20'h00013));
        chk("t6_no_sdr", 32'(sdr_req), 32'd0);
        chk("t6_no_valid", 32'(rom_valid), 32'd0);
        rom_req = 1'b1;
        push(20'h00013);
        tick();
        chk("t6_hit", 32'(rom_valid), 32'd1);
        rom_req = 1'b0;
        tick();
        tick();

        // reset in the middle of a fetch
        lat_fix = 4;
        rom_addr = 20'h00055;
        rom_req = 1'b1;
        tick();
        tick();
        #1;
        reset_n = 1'b0;
        #1;
        chk("t1_valid", 32'(rom_valid), 32'd0);
        chk("t1_sdr_req", 32'(sdr_req), 32'd0);
        chk("t1_sdr_addr", 32'(sdr_addr), 32'd0);
        chk("t1_data", rom_data, 32'd0);
        rom_req = 1'b0;
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("t1_quiet_valid", 32'(rom_valid), 32'd0);
            chk("t1_quiet_req", 32'(sdr_req), 32'd0);
        end
        rom_addr = 20'h00013;
        rom_req = 1'b1;
        push(20'h00013);
        tick();
        chk("t1_have_cleared", 32'(rom_valid), 32'd0);
        wait_valid("t1_refetch", 40);
        rom_req = 1'b0;
        tick();
        tick();

        // randomized traffic
        lat_fix = 0;
        for (int t = 0; t < 120; t++) begin
            a = 20'($urandom_range(0, 7));
            mode = int'($urandom_range(0, 2));
            rom_addr = a;
            rom_req = 1'b1;
            if (mode == 0 || (held_ok && held_w == a)) begin
                push(a);
                wait_valid("rnd_valid", 40);
                repeat ($urandom_range(0, 3)) tick();
            end else begin
                wait_ack("rnd_ack", 20);
                if (mode == 1) begin
                    rom_req = 1'b0;
                    repeat (10) tick();
                end else begin
                    b = 20'($urandom_range(8, 15));
                    rom_addr = b;
                    push(b);
                    wait_valid("rnd_chg_valid", 40);
                    repeat ($urandom_range(0, 3)) tick();
                end
            end
            rom_req = 1'b0;
            repeat ($urandom_range(1, 2)) tick();
        end

        repeat (4) tick();
        chk("sb_drained", 32'(sbq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tile_rom_responder.md
Name: tile_rom_responder

Overview:
- Responder end of the cache-miss ROM port: accepts a level-held `rom_req`/`rom_addr` from the tile/program cache and returns 32-bit `rom_data` with a level `rom_valid`.
- Fetches each 32-bit word as two 16-bit reads from the SDRAM controller's request/ack channel and assembles them big-endian.
- Sits between the cache and the SDRAM arbiter port.

Parameters:
- ADDR_W, 20, width of `rom_addr` (32-bit word index).
- SDR_AW, 24, width of `sdr_addr` (16-bit word address).
- BASE, 24'h000000, SDRAM 16-bit word offset of this ROM region.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- rom_req  in  1  level request from cache; held high while address is wanted.
- rom_addr  in  ADDR_W  32-bit word index; stable while `rom_req` is high for a given request.
- rom_data  out  32  assembled word; valid while `rom_valid` is high.
- rom_valid  out  1  level; high while `rom_data` matches the current `rom_addr` and `rom_req` is high.
- sdr_req  out  1  level request to SDRAM controller.
- sdr_addr  out  SDR_AW  16-bit word address.
- sdr_ack  in  1  one-cycle pulse; `sdr_data` valid in the same cycle.
- sdr_data  in  16  read data.

Behaviour:
- Reset (async assert, sync deassert by use): state=IDLE, `rom_valid`=0, `rom_data`=0, `sdr_req`=0, `sdr_addr`=0, `have`=0.
- Registers: `cur_addr` (ADDR_W), `hi` (16), `have` (1, data held for `cur_addr`).
- Address map: `sdr_addr` = BASE + {cur_addr,1'b0} for the high half, then +1 for the low half. Arithmetic is SDR_AW wide; wrap at 2^SDR_AW is ignored.
- New request: `rom_req` high and (`have`=0 or `rom_addr` != `cur_addr`) while in IDLE.
- IDLE:
  - On a new request: `cur_addr`<=`rom_addr`, `have`<=0, `rom_valid`<=0, `sdr_req`<=1, `sdr_addr`<=high-half address; go RD_HI.
- RD_HI:
  - On `sdr_ack`: `hi`<=`sdr_data`, `sdr_addr`<=`sdr_addr`+1, `sdr_req` stays 1; go RD_LO.
- RD_LO:
  - On `sdr_ack`: `rom_data`<={`hi`,`sdr_data`}, `sdr_req`<=0, `have`<=1; go IDLE.
- rom_valid (registered):
  - Set to 1 in the cycle after the RD_LO ack, provided `rom_req` is high and `rom_addr`==`cur_addr`.
  - Otherwise it is 1 only when IDLE, `have`=1, `rom_req`=1 and `rom_addr`==`cur_addr`.
  - Drops the cycle after `rom_req` falls or `rom_addr` changes.
- Minimum latency: request seen at cycle 0, acks at cycles a1 < a2, `rom_valid` high at cycle a2+1. With acks on consecutive cycles, latency is 4 cycles.
- A re-request of the same address after `rom_req` falls and rises again, with `have`=1, gets `rom_valid` the next cycle with no SDRAM traffic (single-entry hold).
- Mid-fetch `rom_req` drop:
  - The SDRAM transaction is not aborted; both halves complete and `have` is set.
  - `rom_valid` stays 0 until a matching request arrives.
- Mid-fetch address change: the current fetch completes; IDLE then sees a mismatch and refetches. No stale `rom_valid` is ever raised.
- `sdr_ack` outside RD_HI/RD_LO is ignored.
- `sdr_req` is never dropped between the two halves. `sdr_addr` changes only on an ack or an IDLE launch.
- Reset mid-fetch: return to the reset state immediately. The outstanding ack is ignored because the state is IDLE.

Decomposition:
- Shared package `rom_port_pkg`:
  - state enum {IDLE, RD_HI, RD_LO}.
  - ADDR_W / SDR_AW defaults.
  - Function for word-to-halfword address mapping.
- No sub-module; a single FSM module, about 150 lines.

Test Plan:
1. Reset low mid-operation -> all outputs 0 within the same cycle; `sdr_ack` pulses afterwards produce no `rom_valid`.
2. BASE=0x100000, `rom_req`=1, `rom_addr`=0x00012; SDRAM returns 0xDEAD then 0xBEEF with ack latency 3 -> `sdr_addr` 0x100024 then 0x100025; `rom_data`=0xDEADBEEF; `rom_valid` rises the cycle after the second ack.
3. After case 2, drop `rom_req` for 2 cycles, re-raise with 0x00012 -> `rom_valid`=1 the next cycle, `sdr_req` stays 0.
4. Drop `rom_req` between the two acks -> both halves consumed, `rom_valid` stays 0; a later request for the same address is valid in 1 cycle with no SDRAM traffic.
5. Change `rom_addr` 0x00012 -> 0x00013 while in RD_LO -> `rom_valid` never high for 0x00012 data; a second fetch at `sdr_addr` 0x100026/0x100027 follows; `rom_valid` is asserted with the new data.
6. Spurious `sdr_ack` while IDLE -> no state change, `rom_data` unchanged.
